// File: rtl/aer_pkg.sv
// Shared types and constants for the clocked AER transmit scheduler.
package aer_pkg;

    localparam int AER_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_ACKED,
        ST_WAIT_LO
    } aer_st_t;

endpackage

// File: rtl/aer_tx_sched_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping N_CH-1 -> 0.
module rr_pick
    import aer_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int ADDR_W = AER_ADDR_W
) (
    input  logic [N_CH-1:0]   req,
    input  logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W-1:0] win,
    output logic              any
);

    // Scan from the farthest offset down so the closest request to ptr is written last.
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_CH;
            if (req[idx]) begin
                win = ADDR_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aer_tx_sched.sv
// Shares one off-chip AER bus among N_CH spike requesters with round-robin
// selection and a 4-phase req/ack handshake; aer_ack is synchronized inside.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no transaction; waits for en, a pending request and ack_s=0
// ST_SETUP   | address driven, aer_req held low for SETUP cycles
// ST_REQ     | aer_req high, waiting for ack_s=1 (timeout -> WAIT_LO)
// ST_ACKED   | one cycle: aer_req low, spk_ack pulse, ptr advanced
// ST_WAIT_LO | waiting for ack_s=0 (timeout -> IDLE)
module aer_tx_sched
    import aer_pkg::*;
#(
    parameter int N_CH   = 8,
    parameter int ADDR_W = AER_ADDR_W,
    parameter int SETUP  = 1,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   spk_req,
    output logic [N_CH-1:0]   spk_ack,
    output logic [ADDR_W-1:0] aer_addr,
    output logic              aer_req,
    input  logic              aer_ack,
    output logic              busy,
    output logic              to_err,
    input  logic              err_clr
);

    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam int SU_W   = $clog2(SETUP + 1);
    localparam int CNT_W  = (TO_W > SU_W) ? TO_W : SU_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(SETUP - 1);

    aer_st_t             state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   ptr_d;
    logic [ADDR_W-1:0]   aer_addr_q;
    logic                aer_req_q;
    logic [N_CH-1:0]     spk_ack_q;
    logic                to_err_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ack_meta_q;
    logic                ack_s_q;
    logic [ADDR_W-1:0]   pick_win;
    logic                pick_any;

    rr_pick #(
        .N_CH   (N_CH),
        .ADDR_W (ADDR_W)
    ) u_rr_pick (
        .req (spk_req),
        .ptr (ptr_q),
        .win (pick_win),
        .any (pick_any)
    );

    assign ptr_d = (aer_addr_q == ADDR_W'(N_CH - 1)) ? '0 : aer_addr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            aer_addr_q <= '0;
            aer_req_q  <= 1'b0;
            spk_ack_q  <= '0;
            to_err_q   <= 1'b0;
            cnt_q      <= '0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= aer_ack;
            ack_s_q    <= ack_meta_q;
            spk_ack_q  <= '0;
            cnt_q      <= cnt_q + CNT_W'(1);
            // A timeout assignment further down overrides this clear.
            if (err_clr) begin
                to_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (en && pick_any && !ack_s_q) begin
                        aer_addr_q <= pick_win;
                        state_q    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SU_LAST) begin
                        aer_req_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_s_q) begin
                        aer_req_q <= 1'b0;
                        spk_ack_q <= N_CH'(1) << aer_addr_q;
                        ptr_q     <= ptr_d;
                        cnt_q     <= '0;
                        state_q   <= ST_ACKED;
                    end else if (cnt_q == TO_LAST) begin
                        aer_req_q <= 1'b0;
                        to_err_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT_LO;
                    end
                end
                ST_ACKED: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!ack_s_q) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        to_err_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    aer_req_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign spk_ack  = spk_ack_q;
    assign aer_addr = aer_addr_q;
    assign aer_req  = aer_req_q;
    assign busy     = (state_q != ST_IDLE);
    assign to_err   = to_err_q;

endmodule

// File: tb/tb_aer_tx_sched.sv
// Bench for aer_tx_sched: timeline model of each transaction checked every cycle,
// plus directed scenarios with hand-computed grant orders and timings.
module tb_aer_tx_sched;

    localparam int N      = 8;
    localparam int SETUP  = 1;
    localparam int TO_CYC = 255;

    logic       clk = 1'b0;
    logic       rst, en, aer_ack, err_clr;
    logic [7:0] spk_req, spk_ack, pend, hold, tog;
    logic [2:0] aer_addr;
    logic       aer_req, busy, to_err;

    int n_chk = 0;
    int n_err = 0;
    int rx_mode, rx_dly, rx_cnt;

    // model / observation state
    int   cyc, m_ptr, t_start, t_ack, t_fall, t_to, exp_addr;
    bit   m_err, in_txn, timed_out, prev_ok, exp_req, exp_busy, exp_start;
    logic [7:0] exp_spk, p_req, last_spk;
    logic p_en, p_clr, p_aer_req, a_h1, a_h2, a_h3;
    int   req_run, last_run, rise_cyc, spk_cnt;
    int   glog[$];

    always #5 clk = ~clk;

    assign spk_req = pend | hold | tog;

    aer_tx_sched #(
        .N_CH   (N),
        .ADDR_W (3),
        .SETUP  (SETUP),
        .TO_CYC (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spk_req  (spk_req),
        .spk_ack  (spk_ack),
        .aer_addr (aer_addr),
        .aer_req  (aer_req),
        .aer_ack  (aer_ack),
        .busy     (busy),
        .to_err   (to_err),
        .err_clr  (err_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expire(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: wait expired at %0t", nm, $time);
    endtask

    function automatic int rr_model(input logic [7:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // what: 0 aer_req high, 1 aer_req low, 2 idle, 3 grant log reaches arg
    task automatic wait_for(input int what, input int arg, input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(posedge clk);
            #1;
            case (what)
                0:       ok = aer_req;
                1:       ok = !aer_req;
                2:       ok = !busy;
                default: ok = (glog.size() >= arg);
            endcase
        end
        if (!ok) expire(nm);
    endtask

    // receiver: 0 compliant (acks after rx_dly cycles of aer_req), 1 mute, 2 toggling
    initial begin
        aer_ack = 1'b0;
        rx_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rx_mode)
                0: begin
                    if (aer_ack) begin
                        if (!aer_req) aer_ack = 1'b0;
                    end else if (aer_req) begin
                        rx_cnt++;
                        if (rx_cnt >= rx_dly) begin
                            aer_ack = 1'b1;
                            rx_cnt  = 0;
                        end
                    end else begin
                        rx_cnt = 0;
                    end
                end
                1: begin
                    aer_ack = 1'b0;
                    rx_cnt  = 0;
                end
                default: aer_ack = ~aer_ack;
            endcase
        end
    end

    // requesters drop their bit once acknowledged
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pend = pend & ~spk_ack;
        end
    end

    // Each transaction is a timeline: start, aer_req from start+SETUP until 3 cycles
    // after the receiver's ack (sync latency) or TO_CYC cycles, busy until 3 cycles
    // after the ack falls.
    initial begin
        cyc = 0; m_ptr = 0; m_err = 0; in_txn = 0; prev_ok = 0;
        a_h1 = 0; a_h2 = 0; a_h3 = 0; req_run = 0; last_run = 0;
        rise_cyc = 0; spk_cnt = 0; last_spk = '0; p_aer_req = 0;
        p_en = 0; p_clr = 0; p_req = '0;
        t_start = 0; t_ack = -1; t_fall = -1; t_to = 0; exp_addr = 0; timed_out = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_ptr = 0; m_err = 0; in_txn = 0; prev_ok = 0;
                a_h1 = 0; a_h2 = 0; a_h3 = 0; req_run = 0; p_aer_req = 0;
            end else begin
                if (prev_ok && p_clr) m_err = 0;
                if (in_txn) begin
                    if (t_ack < 0 && aer_ack && aer_req) t_ack = cyc;
                    if (t_ack >= 0 && t_fall < 0 && !aer_ack) t_fall = cyc;
                    if (t_ack < 0 && cyc == t_to) begin
                        m_err     = 1;
                        timed_out = 1;
                    end
                    exp_req  = (cyc - t_start >= SETUP) && (cyc < t_to) && (t_ack < 0 || cyc < t_ack + 3);
                    exp_spk  = (t_ack >= 0 && cyc == t_ack + 3) ? 8'(1 << exp_addr) : 8'h00;
                    exp_busy = !((t_fall >= 0 && cyc >= t_fall + 3) || (timed_out && cyc >= t_to + 1));
                    chk("m_addr", aer_addr, exp_addr);
                    chk("m_req", aer_req, exp_req);
                    chk("m_spk_ack", spk_ack, exp_spk);
                    chk("m_busy", busy, exp_busy);
                    if (exp_spk != 0) begin
                        glog.push_back(exp_addr);
                        m_ptr = (exp_addr + 1) % N;
                    end
                    if (!exp_busy) in_txn = 0;
                end else begin
                    exp_start = prev_ok && p_en && (p_req != 0) && !a_h3;
                    chk("m_start", busy, exp_start);
                    chk("m_idle_req", aer_req, 0);
                    chk("m_idle_spk", spk_ack, 0);
                    if (busy) begin
                        exp_addr = rr_model(p_req, m_ptr);
                        chk("m_grant", aer_addr, exp_addr);
                        in_txn    = 1;
                        t_start   = cyc;
                        t_to      = cyc + SETUP + TO_CYC;
                        t_ack     = -1;
                        t_fall    = -1;
                        timed_out = 0;
                    end
                end
                chk("m_to_err", to_err, m_err);
                if (aer_req && !p_aer_req) rise_cyc = cyc;
                if (aer_req) req_run++;
                else if (req_run > 0) begin
                    last_run = req_run;
                    req_run  = 0;
                end
                if (spk_ack != 0) begin
                    spk_cnt++;
                    last_spk = spk_ack;
                end
                p_aer_req = aer_req; p_en = en; p_req = spk_req; p_clr = err_clr;
                a_h3 = a_h2; a_h2 = a_h1; a_h1 = aer_ack;
                prev_ok = 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, req_cyc, spk0;
        bit quiet;
        rst = 1'b1; en = 1'b0; err_clr = 1'b0; pend = '0; hold = '0; tog = '0;
        rx_mode = 2; rx_dly = 3;

        // 1: reset with inputs toggling, then idle with no requests
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            en = ~en; tog = ~tog; err_clr = ~err_clr;
            @(negedge clk);
            #1;
            chk("t1_reset_outputs", {spk_ack, aer_addr, aer_req, busy, to_err}, 0);
        end
        @(posedge clk);
        #1;
        en = 1'b0; tog = '0; err_clr = 1'b0; rx_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_req", aer_req, 0);

        // 2: single request, receiver acks after 3 cycles
        base = glog.size();
        spk0 = spk_cnt;
        pend = 8'h04;
        req_cyc = cyc + 1;
        wait_for(0, 0, 20, "t2_req_rise");
        @(negedge clk);
        #1;
        chk("t2_addr", aer_addr, 2);
        chk("t2_req_latency", rise_cyc - req_cyc, 2);
        wait_for(2, 0, 40, "t2_done");
        chk("t2_grant", glog.size() > base ? glog[base] : -1, 2);
        chk("t2_spk_ack_val", last_spk, 8'h04);
        chk("t2_spk_ack_width", spk_cnt - spk0, 1);
        pend = 8'h09;
        wait_for(3, base + 3, 80, "t2_ptr_follow");
        wait_for(2, 0, 40, "t2_idle");
        chk("t2_ptr3_grant", glog.size() > base + 1 ? glog[base + 1] : -1, 3);
        chk("t2_wrap_grant", glog.size() > base + 2 ? glog[base + 2] : -1, 0);

        // 3: all requesters held high after reset
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = glog.size();
        hold = 8'hFF;
        wait_for(3, base + 10, 400, "t3_grants");
        hold = 8'h00;
        wait_for(2, 0, 40, "t3_idle");
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t3_grant_%0d", i), glog.size() > base + i ? glog[base + i] : -1, i % 8);
        end

        // 4: mute receiver -> timeout; err_clr held high through it
        rx_mode = 1;
        base = glog.size();
        pend = 8'h10;
        wait_for(0, 0, 20, "t4_req_rise");
        en = 1'b0;
        err_clr = 1'b1;
        wait_for(1, 0, 300, "t4_timeout");
        @(negedge clk);
        #1;
        chk("t4_req_len", last_run, 255);
        chk("t4_to_err_set", to_err, 1);
        chk("t4_no_spk_ack", glog.size(), base);
        @(posedge clk);
        #1;
        chk("t4_to_err_clr", to_err, 0);
        err_clr = 1'b0;
        wait_for(2, 0, 10, "t4_idle");
        rx_mode = 0;
        en = 1'b1;
        wait_for(3, base + 1, 60, "t4_retry");
        wait_for(2, 0, 40, "t4_retry_idle");
        chk("t4_retry_grant", glog.size() > base ? glog[base] : -1, 4);

        // 5: en dropped while in REQ
        base = glog.size();
        pend = 8'h08;
        wait_for(0, 0, 20, "t5_req_rise");
        en = 1'b0;
        pend = pend | 8'h02;
        wait_for(3, base + 1, 40, "t5_finish");
        wait_for(2, 0, 40, "t5_idle");
        chk("t5_grant", glog.size() > base ? glog[base] : -1, 3);
        quiet = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (aer_req || busy) quiet = 1'b0;
        end
        chk("t5_blocked", quiet, 1);
        en = 1'b1;
        wait_for(3, base + 2, 60, "t5_resume");
        wait_for(2, 0, 40, "t5_resume_idle");
        chk("t5_resume_grant", glog.size() > base + 1 ? glog[base + 1] : -1, 1);

        // 6: reset pulse while aer_req is high
        base = glog.size();
        pend = 8'h81;
        wait_for(0, 0, 20, "t6_req_rise");
        chk("t6_pre_addr", aer_addr, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_drop", {aer_req, busy, spk_ack}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_for(0, 0, 20, "t6_resend");
        chk("t6_resend_addr", aer_addr, 0);
        wait_for(3, base + 2, 80, "t6_grants");
        wait_for(2, 0, 40, "t6_idle");
        chk("t6_grant0", glog.size() > base ? glog[base] : -1, 0);
        chk("t6_grant1", glog.size() > base + 1 ? glog[base + 1] : -1, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
